// File: rtl/kavach_timing_supervisor_pkg.sv
// Shared types for the Kavach timing supervisor.
// Holds the FSM state codes and the monitor severity codes.
package kavach_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    CALIB    = 3'd2,
    ARMED    = 3'd3,
    ALARM    = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam logic [1:0] SEV_NONE = 2'd0;
  localparam logic [1:0] SEV_LOW  = 2'd1;
  localparam logic [1:0] SEV_MID  = 2'd2;
  localparam logic [1:0] SEV_HIGH = 2'd3;

endpackage

// File: rtl/kavach_timing_supervisor_if.sv
// Monitor-facing bundle: the monitor drives ready/period/severity
// and receives period_cfg/use_cfg from the supervisor.
interface kavach_mon_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 monitor_ready;
  logic [CNT_WIDTH-1:0] measured_period;
  logic [1:0]           severity;
  logic [CNT_WIDTH-1:0] period_cfg;
  logic                 use_cfg;

  modport master (
    output monitor_ready, measured_period, severity,
    input  period_cfg, use_cfg
  );

  modport slave (
    input  monitor_ready, measured_period, severity,
    output period_cfg, use_cfg
  );
endinterface

// File: rtl/kavach_timing_supervisor_cal_accum.sv
// Calibration accumulator: sample count, sum, min/max, bad flag.
// Ports: clr, sample_en, sample in; done, avg, fail out.
module kavach_cal_accum #(
  parameter int                   CNT_WIDTH  = 16,
  parameter int                   CAL_LOG2   = 3,
  parameter logic [CNT_WIDTH-1:0] CAL_SPREAD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 sample_en,
  input  logic [CNT_WIDTH-1:0] sample,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] avg,
  output logic                 fail
);

  localparam int SW = CNT_WIDTH + CAL_LOG2;

  logic [CAL_LOG2:0]    cnt;
  logic [SW-1:0]        sum;
  logic [CNT_WIDTH-1:0] mn;
  logic [CNT_WIDTH-1:0] mx;
  logic                 bad;

  // cnt top bit set means the full sample set is in
  assign done = cnt[CAL_LOG2];
  assign avg  = sum[SW-1:CAL_LOG2];
  assign fail = bad || ((mx - mn) > CAL_SPREAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
      mn  <= '1;
      mx  <= '0;
      bad <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sum <= '0;
      mn  <= '1;
      mx  <= '0;
      bad <= 1'b0;
    end else if (sample_en && !done) begin
      cnt <= cnt + 1'b1;
      sum <= sum + {{CAL_LOG2{1'b0}}, sample};
      if (sample < mn) mn <= sample;
      if (sample > mx) mx <= sample;
      if (sample == '0 || sample == '1) bad <= 1'b1;
    end
  end

endmodule

// File: rtl/kavach_timing_supervisor.sv
// Kavach supervisor: warm-up wait, period calibration, arm, alarm.
// Ports: start/abort/clear_req in, mon bundle, status outputs.
module kavach_timing_supervisor
  import kavach_pkg::*;
#(
  parameter int                   CNT_WIDTH     = 16,
  parameter int                   CAL_LOG2      = 3,
  parameter logic [15:0]          SAMPLE_GAP    = 16'd64,
  parameter logic [CNT_WIDTH-1:0] CAL_SPREAD    = 2,
  parameter logic [19:0]          READY_TIMEOUT = 20'd1000000,
  parameter logic [7:0]           ESC_CYCLES    = 8'd4,
  parameter logic [1:0]           ALARM_SEV     = SEV_MID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        clear_req,
  output logic        clear_ack,
  kavach_mon_if.slave mon,
  output logic        armed,
  output logic        alarm,
  output logic [1:0]  alarm_sev,
  output logic        cal_fail,
  output logic        busy,
  output logic [2:0]  state_o
);

  state_t state;
  state_t nxt;

  logic [15:0]          gap;
  logic [19:0]          tmo;
  logic [7:0]           esc;
  logic                 gap_end;
  logic                 sev_hit;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 acc_done;
  logic                 acc_fail;
  logic [CNT_WIDTH-1:0] acc_avg;

  assign gap_end = (gap == SAMPLE_GAP - 16'd1);
  assign sev_hit = (mon.severity >= ALARM_SEV);
  assign acc_clr = abort || (state != CALIB);
  assign acc_en  = (state == CALIB) && gap_end && !abort;

  kavach_cal_accum #(
    .CNT_WIDTH (CNT_WIDTH),
    .CAL_LOG2  (CAL_LOG2),
    .CAL_SPREAD(CAL_SPREAD)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .sample_en(acc_en),
    .sample   (mon.measured_period),
    .done     (acc_done),
    .avg      (acc_avg),
    .fail     (acc_fail)
  );

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else if (clear_req && state == ALARM) begin
      nxt = CALIB;
    end else if (clear_req && state == FAULT) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (start) nxt = WAIT_RDY;
        WAIT_RDY:
          if (mon.monitor_ready) nxt = CALIB;
          else if (tmo == READY_TIMEOUT - 20'd1) nxt = FAULT;
        CALIB:
          if (acc_done) nxt = acc_fail ? FAULT : ARMED;
        ARMED:
          if (sev_hit && esc == ESC_CYCLES - 8'd1) nxt = ALARM;
        ALARM: nxt = ALARM;
        FAULT: nxt = FAULT;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gap            <= '0;
      tmo            <= '0;
      esc            <= '0;
      mon.period_cfg <= '0;
      mon.use_cfg    <= 1'b0;
      armed          <= 1'b0;
      alarm          <= 1'b0;
      alarm_sev      <= '0;
      cal_fail       <= 1'b0;
      busy           <= 1'b0;
      clear_ack      <= 1'b0;
      state_o        <= '0;
    end else begin
      state <= nxt;

      if (abort || state != CALIB || gap_end) gap <= '0;
      else gap <= gap + 16'd1;

      if (!abort && state == WAIT_RDY) tmo <= tmo + 20'd1;
      else tmo <= '0;

      if (!abort && state == ARMED && sev_hit) esc <= esc + 8'd1;
      else esc <= '0;

      if (!abort && state == CALIB && acc_done && !acc_fail)
        mon.period_cfg <= acc_avg;

      // entry latches the triggering severity, then tracks the max
      if (nxt != ALARM) alarm_sev <= '0;
      else if (state == ARMED) alarm_sev <= mon.severity;
      else if (mon.severity > alarm_sev) alarm_sev <= mon.severity;

      clear_ack <= !abort && clear_req &&
                   (state == ALARM || state == FAULT);

      mon.use_cfg <= (nxt == ARMED) || (nxt == ALARM);
      armed       <= (nxt == ARMED);
      alarm       <= (nxt == ALARM);
      cal_fail    <= (nxt == FAULT);
      busy        <= (nxt == WAIT_RDY) || (nxt == CALIB);
      state_o     <= nxt;
    end
  end

endmodule

// File: tb/tb_kavach_timing_supervisor.sv
// Self-checking bench for kavach_timing_supervisor.
// Expected output records are queued at drive time, popped after the edge.
module tb_kavach_timing_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       clear_req;
  logic       clear_ack;
  logic       armed;
  logic       alarm;
  logic [1:0] alarm_sev;
  logic       cal_fail;
  logic       busy;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  kavach_mon_if #(.CNT_WIDTH(16)) mon ();

  kavach_timing_supervisor #(
    .CNT_WIDTH    (16),
    .CAL_LOG2     (3),
    .SAMPLE_GAP   (16'd64),
    .CAL_SPREAD   (16'd2),
    .READY_TIMEOUT(20'd100),
    .ESC_CYCLES   (8'd4),
    .ALARM_SEV    (2'b10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .clear_req(clear_req),
    .clear_ack(clear_ack),
    .mon      (mon),
    .armed    (armed),
    .alarm    (alarm),
    .alarm_sev(alarm_sev),
    .cal_fail (cal_fail),
    .busy     (busy),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [26:0] v;
  } exp_t;

  typedef struct {
    logic [1:0] sev;
    logic [2:0] st;
    logic [1:0] asev;
  } vec_t;

  exp_t q[$];
  vec_t tbl[10];

  function automatic logic [26:0] act();
    return {state_o, armed, alarm, cal_fail, busy, mon.use_cfg,
            mon.period_cfg, alarm_sev, clear_ack};
  endfunction

  task automatic expect_o(string n, logic [2:0] st, logic [15:0] pc,
                          logic [1:0] as, logic ack);
    exp_t e;
    e.name = n;
    e.v = {st, st == 3'd3, st == 3'd4, st == 3'd5,
           st == 3'd1 || st == 3'd2, st == 3'd3 || st == 3'd4,
           pc, as, ack};
    q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected record queued");
    end else begin
      e = q.pop_front();
      if (act() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h t=%0t",
                 e.name, act(), e.v, $time);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic calib_samples(logic [15:0] base, logic [15:0] odd);
    for (int k = 0; k < 8; k++) begin
      mon.measured_period = (k == 3) ? odd : base;
      if (k < 7) run(64);
      else begin
        run(63);
        expect_o("calib_last", 3'd2, mon.period_cfg, 2'd0, 1'b0);
        step();
      end
    end
  endtask

  initial begin
    tbl[0] = '{2'd2, 3'd3, 2'd0};
    tbl[1] = '{2'd2, 3'd3, 2'd0};
    tbl[2] = '{2'd2, 3'd3, 2'd0};
    tbl[3] = '{2'd0, 3'd3, 2'd0};
    tbl[4] = '{2'd2, 3'd3, 2'd0};
    tbl[5] = '{2'd2, 3'd3, 2'd0};
    tbl[6] = '{2'd2, 3'd3, 2'd0};
    tbl[7] = '{2'd2, 3'd4, 2'd2};
    tbl[8] = '{2'd3, 3'd4, 2'd3};
    tbl[9] = '{2'd1, 3'd4, 2'd3};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    clear_req = 1'b0;
    mon.monitor_ready = 1'b0;
    mon.measured_period = '0;
    mon.severity = 2'd0;
    #3;
    expect_o("reset", 3'd0, 16'd0, 2'd0, 1'b0);
    pop_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // nominal calibration at period 2
    mon.monitor_ready = 1'b1;
    mon.measured_period = 16'd2;
    start = 1'b1;
    expect_o("start_wait", 3'd1, 16'd0, 2'd0, 1'b0);
    step();
    start = 1'b0;
    expect_o("enter_calib", 3'd2, 16'd0, 2'd0, 1'b0);
    step();
    run(511);
    expect_o("calib_514", 3'd2, 16'd0, 2'd0, 1'b0);
    step();
    expect_o("armed_515", 3'd3, 16'd2, 2'd0, 1'b0);
    step();

    // escalation table
    for (int i = 0; i < 10; i++) begin
      mon.severity = tbl[i].sev;
      expect_o($sformatf("esc%0d", i), tbl[i].st, 16'd2,
               tbl[i].asev, 1'b0);
      step();
    end

    // clear in alarm, recalibrate at period 4
    mon.severity = 2'd0;
    mon.measured_period = 16'd4;
    clear_req = 1'b1;
    expect_o("alarm_clear", 3'd2, 16'd2, 2'd0, 1'b1);
    step();
    expect_o("clear_held", 3'd2, 16'd2, 2'd0, 1'b0);
    step();
    clear_req = 1'b0;
    run(510);
    expect_o("recal_last", 3'd2, 16'd2, 2'd0, 1'b0);
    step();
    expect_o("rearmed", 3'd3, 16'd4, 2'd0, 1'b0);
    step();

    // abort from armed, then abort mid-calib with clear_req
    abort = 1'b1;
    expect_o("abort_armed", 3'd0, 16'd4, 2'd0, 1'b0);
    step();
    abort = 1'b0;
    start = 1'b1;
    expect_o("restart_wait", 3'd1, 16'd4, 2'd0, 1'b0);
    step();
    start = 1'b0;
    expect_o("restart_calib", 3'd2, 16'd4, 2'd0, 1'b0);
    step();
    run(100);
    abort = 1'b1;
    clear_req = 1'b1;
    expect_o("abort_calib", 3'd0, 16'd4, 2'd0, 1'b0);
    step();
    abort = 1'b0;
    clear_req = 1'b0;

    // spread fault: 2,2,2,6,2,2,2,2
    start = 1'b1;
    expect_o("sp_wait", 3'd1, 16'd4, 2'd0, 1'b0);
    step();
    start = 1'b0;
    expect_o("sp_calib", 3'd2, 16'd4, 2'd0, 1'b0);
    step();
    calib_samples(16'd2, 16'd6);
    expect_o("sp_fault", 3'd5, 16'd4, 2'd0, 1'b0);
    step();
    clear_req = 1'b1;
    start = 1'b1;
    expect_o("fault_clear", 3'd0, 16'd4, 2'd0, 1'b1);
    step();
    expect_o("restart_held", 3'd1, 16'd4, 2'd0, 1'b0);
    step();
    clear_req = 1'b0;
    start = 1'b0;
    expect_o("edge_calib", 3'd2, 16'd4, 2'd0, 1'b0);
    step();

    // spread exactly at limit, truncating average 26/8 -> 3
    calib_samples(16'd3, 16'd5);
    expect_o("edge_armed", 3'd3, 16'd3, 2'd0, 1'b0);
    step();

    // asynchronous reset mid-armed
    #3;
    rst_n = 1'b0;
    #1;
    expect_o("async_reset", 3'd0, 16'd0, 2'd0, 1'b0);
    pop_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ready timeout
    mon.monitor_ready = 1'b0;
    start = 1'b1;
    expect_o("to_wait", 3'd1, 16'd0, 2'd0, 1'b0);
    step();
    start = 1'b0;
    run(98);
    expect_o("to_wait_99", 3'd1, 16'd0, 2'd0, 1'b0);
    step();
    expect_o("to_fault_100", 3'd5, 16'd0, 2'd0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
